mig7_truth_table_extractor: RTL
===============================

Name: mig7_truth_table_extractor

Overview:
- Sequential characterisation engine for the 7-input single-output majority-network functions in this collection.
- Drives all 128 input vectors to a function-under-test (FUT) in ascending order and samples its output each cycle.
- Assembles the 128-bit truth table, counts the ones, and compares the result against an expected table.
- Sits beside each generated 7-input network as its self-check harness; the same block is used in silicon BIST and in the regression bench.

Parameters:
- SAMPLE_DELAY, 0, cycles between driving probe_x and a valid fut_out (0 = purely combinational FUT); legal range 0..7.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected_tt  in  128  reference truth table; must be stable from start until done.
- probe_x  out  7  input vector to the FUT; bit0 = x0 … bit6 = x6.
- probe_valid  out  1  high while probe_x carries a sweep vector.
- fut_out  in  1  FUT output, valid SAMPLE_DELAY cycles after the matching probe_x.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when the result is final.
- tt  out  128  captured table; tt[i] = f(x = i), so tt[127] = f(1111111).
- tt_valid  out  1  tt, ones_count and match are final; held until the next accepted start or rst.
- ones_count  out  8  number of 1s in tt, range 0..128.
- match  out  1  (tt == expected_tt); meaningful only while tt_valid = 1.

Behaviour:
- Reset values:
  - State = IDLE.
  - probe_x = 0, probe_valid = 0, busy = 0, done = 0.
  - tt = 0, tt_valid = 0, ones_count = 0, match = 0.
  - Capture pipeline cleared.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start = 1 at cycle T moves to SWEEP at T+1.
  - Clears tt, ones_count, tt_valid and match on that same edge.
- SWEEP:
  - Index counter idx is 7 bits and starts at 0. probe_x = idx and probe_valid = 1.
  - idx increments every cycle. Cycles T+1 .. T+128 present idx 0..127.
  - After presenting 127: go to DRAIN if SAMPLE_DELAY > 0, otherwise to DONE.
  - idx must not wrap back to 0 and re-present vectors.
- Capture pipeline:
  - A SAMPLE_DELAY-deep shift register carries {valid, idx} alongside each probe.
  - When the delayed valid is 1: set tt[delayed_idx] = fut_out and add fut_out to ones_count.
  - With SAMPLE_DELAY = 0, capture happens on the same edge that advances idx.
  - ones_count is 8 bits and saturates naturally at 128; it never overflows.
- DRAIN:
  - probe_valid = 0 and probe_x holds 127.
  - Stays SAMPLE_DELAY cycles until the final capture has occurred, then goes to DONE.
- DONE (one cycle):
  - Entered at cycle T+129+SAMPLE_DELAY.
  - done = 1, tt_valid = 1, match is registered.
  - Returns to IDLE next cycle; tt, ones_count, match and tt_valid are held there.
- Total latency from start to done: 129 + SAMPLE_DELAY cycles.
- start while busy or in DONE is ignored; no queuing.
- start on the same cycle as rst: rst wins and the block stays in IDLE.
- rst mid-sweep or mid-drain:
  - Immediate return to reset values on the next edge.
  - No done pulse, and partial tt is discarded.
- expected_tt changing after start is a protocol violation; the result is undefined and not checked.

Test Plan:
- Reset → state and outputs: assert rst during SWEEP at idx = 40 → next cycle busy = 0, probe_valid = 0, tt = 0, no done pulse ever follows.
- Timing with combinational FUT: SAMPLE_DELAY = 0, FUT f = x0, expected_tt = 128'hAAAA…AAAA.
  - done at exactly T+129.
  - tt = 128'hAAAA…AAAA, ones_count = 64, match = 1.
  - probe_x steps 0..127, with probe_valid high for exactly 128 cycles.
- Delayed capture: SAMPLE_DELAY = 3, FUT = registered 3-stage maj(x0,x1,x2).
  - tt = 128'hE8E8…E8 (16 bytes), ones_count = 64.
  - done at T+132.
- Mismatch and extreme counts:
  - FUT constant 1 with expected_tt = all-ones except bit 0 → ones_count = 128, match = 0.
  - FUT constant 0 → ones_count = 0, tt = 0.
- Start handling: pulse start at T+10 and at the DONE cycle → both ignored.
  - Exactly one done pulse.
  - A following start in IDLE clears tt_valid on the next cycle and runs a fresh sweep.
- Simultaneous events: start and rst together in IDLE → no sweep, busy stays 0.

Source files
------------

// File: rtl/mig7_truth_table_extractor.sv
// rtl/mig7_truth_table_extractor.sv - sweeps all 128 vectors through a 7-input FUT and captures its truth table
module mig7_truth_table_extractor #(
  parameter int SAMPLE_DELAY = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] expected_tt,
  output logic [6:0]   probe_x,
  output logic         probe_valid,
  input  logic         fut_out,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic         tt_valid,
  output logic [7:0]   ones_count,
  output logic         match
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t       state, state_next;
  logic [6:0]   idx;
  logic         cap_valid;
  logic [6:0]   cap_idx;
  logic [127:0] tt_next;
  logic [7:0]   ones_next;

  assign probe_x     = idx;
  assign probe_valid = (state == SWEEP);
  assign busy        = (state == SWEEP) || (state == DRAIN);
  assign done        = (state == DONE);

  // The capture tag {valid, idx} travels alongside the FUT latency so each
  // sample lands in the table slot of the vector that produced it.
  generate
    if (SAMPLE_DELAY == 0) begin : g_nodelay
      assign cap_valid = probe_valid;
      assign cap_idx   = idx;
    end else begin : g_delay
      logic [SAMPLE_DELAY-1:0] pipe_v;
      logic [6:0]              pipe_idx [SAMPLE_DELAY];

      // Shift the probe tag one stage per cycle; reset empties the pipe.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_v <= '0;
          for (int i = 0; i < SAMPLE_DELAY; i++) pipe_idx[i] <= '0;
        end else begin
          pipe_v[0]   <= probe_valid;
          pipe_idx[0] <= idx;
          for (int i = 1; i < SAMPLE_DELAY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
          end
        end
      end

      assign cap_valid = pipe_v[SAMPLE_DELAY-1];
      assign cap_idx   = pipe_idx[SAMPLE_DELAY-1];
    end
  endgenerate

  // Table and count as they will be after this cycle's capture; also feeds
  // the match compare so the final bit is included on the edge into DONE.
  always_comb begin
    tt_next   = tt;
    ones_next = ones_count;
    if (cap_valid) begin
      tt_next[cap_idx] = fut_out;
      ones_next        = ones_count + {7'd0, fut_out};
    end
  end

  // Next-state: sweep 128 vectors, drain the FUT latency, then one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SWEEP;
      SWEEP: if (idx == 7'd127) state_next = (SAMPLE_DELAY > 0) ? DRAIN : DONE;
      DRAIN: if (cap_valid && (cap_idx == 7'd127)) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, index and result registers; idx holds at 127 so no vector repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      tt         <= '0;
      ones_count <= '0;
      tt_valid   <= 1'b0;
      match      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            tt         <= '0;
            ones_count <= '0;
            tt_valid   <= 1'b0;
            match      <= 1'b0;
          end
        end
        SWEEP: begin
          tt         <= tt_next;
          ones_count <= ones_next;
          if (idx != 7'd127) idx <= idx + 7'd1;
        end
        DRAIN: begin
          tt         <= tt_next;
          ones_count <= ones_next;
        end
        DONE: idx <= '0;
        default: ;
      endcase
      if ((state_next == DONE) && (state != DONE)) begin
        tt_valid <= 1'b1;
        match    <= (tt_next == expected_tt);
      end
    end
  end

endmodule
